irrigation_valve_controller: RTL and testbench
==============================================

IRRIGATION_VALVE_CONTROLLER -- requirements
Module: irrigation_valve_controller

Interface
REQ-001 Parameter: ASP_SECONDS, default 22, aspersion dwell in seconds for combined mode; legal range 1..63.
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 tick_1s  input  1  one-clk-wide pulse, once per second.
REQ-005 type_of_irrigation_state  input  2  irrigation request from the upstream state stage: 00 none, 01 aspersion, 10 drip, 11 aspersion-then-drip.
REQ-006 water_low  input  1  reservoir below minimum level; used only when WATER_LEVEL_CHECK_EN is defined.
REQ-007 valve_asp  output  1  aspersion valve drive, registered.
REQ-008 valve_drip  output  1  drip valve drive, registered.
REQ-009 alarm  output  1  fault indicator, registered.
REQ-010 secs_left  output  6  remaining aspersion seconds in combined mode, registered.
REQ-011 state  output  3  current FSM state code, for debug and display.

Function
REQ-012 The FSM SHALL have states IDLE=000, ASP=001, DRIP=010, MIX_ASP=011, MIX_DRIP=100, FAULT=101; codes 110/111 SHALL go to IDLE on the next clk.
REQ-013 In IDLE, request 01->ASP, 10->DRIP, 11->MIX_ASP with the counter loaded to ASP_SECONDS, 00->stay in IDLE; each transition takes effect on the next clk.
REQ-014 In ASP, DRIP, MIX_ASP and MIX_DRIP, any request differing from the one that caused entry SHALL return the FSM to IDLE for exactly one clk with both valves off (break-before-make); the new request is then dispatched from IDLE.
REQ-015 In MIX_ASP, each tick_1s SHALL decrement the counter by 1; a tick while the counter equals 1 SHALL move the FSM to MIX_DRIP with the counter at 0, giving exactly ASP_SECONDS ticks of aspersion.
REQ-016 Without a tick, the counter SHALL hold; tick_1s SHALL be ignored in every state except MIX_ASP.
REQ-017 MIX_DRIP SHALL persist while the request stays 11; aspersion SHALL NOT restart until the FSM has passed through IDLE.
REQ-018 valve_asp=1 exactly in ASP and MIX_ASP; valve_drip=1 exactly in DRIP and MIX_DRIP; both valves SHALL never be 1 in the same cycle.
REQ-019 secs_left SHALL equal the counter in MIX_ASP and 0 in all other states.
REQ-020 Outputs are registered: a valve changes 1 clk after the input event that causes it.
REQ-021 Simultaneous request change and tick in MIX_ASP: the request change wins; the FSM goes to IDLE and the counter is ignored.
REQ-022 alarm=1 only in FAULT.

Reset
REQ-023 While rst_n=0: state=IDLE, counter=0, valve_asp=0, valve_drip=0, alarm=0, secs_left=0, asynchronously; assertion mid-irrigation closes both valves without waiting for a clk edge.
REQ-024 After rst_n deasserts, the first dispatch SHALL occur on the first clk edge that samples a nonzero request.

Configuration
REQ-025 Macro WATER_LEVEL_CHECK_EN defined: water_low=1 in any state other than FAULT SHALL force FAULT on the next clk (valves off, alarm=1, counter=0); this has priority over request changes and ticks.
REQ-026 With WATER_LEVEL_CHECK_EN defined, FAULT SHALL exit to IDLE only when water_low=0 and request=00 in the same cycle (operator acknowledge).
REQ-027 Macro undefined: water_low is ignored, FAULT is unreachable, and alarm is held at 0.

Verification
REQ-028 Request 01 from IDLE -> valve_asp=1 one clk later, valve_drip=0; request 00 -> valve_asp=0 one clk later.
REQ-029 Request 11 with ASP_SECONDS=22 and 22 ticks -> valve_asp=1 and secs_left counts 22..1; on the 22nd tick -> valve_drip=1, valve_asp=0, secs_left=0.
REQ-030 Request 01 changes to 10 -> one clk with both valves 0 (state=000), then valve_drip=1.
REQ-031 rst_n pulsed low during MIX_ASP with secs_left=10 -> valves 0 immediately; request 11 held after release -> counter reloads to 22.
REQ-032 With WATER_LEVEL_CHECK_EN defined: in DRIP, water_low=1 -> alarm=1, valves 0; water_low=0 with request 11 -> remains in FAULT; request 00 -> IDLE, alarm=0.
REQ-033 Tick and request change in the same clk during MIX_ASP -> IDLE; no transition to MIX_DRIP.

Source files
------------

// File: rtl/irrigation_valve_controller_if.sv
// irrigation_valve_controller_if: request/tick inputs and valve/status outputs of the valve controller
interface irrigation_valve_controller_if;
    logic       tick_1s;
    logic [1:0] type_of_irrigation_state;
    logic       water_low;
    logic       valve_asp;
    logic       valve_drip;
    logic       alarm;
    logic [5:0] secs_left;
    logic [2:0] state;
    modport master (
        output tick_1s, type_of_irrigation_state, water_low,
        input  valve_asp, valve_drip, alarm, secs_left, state
    );
    modport slave (
        input  tick_1s, type_of_irrigation_state, water_low,
        output valve_asp, valve_drip, alarm, secs_left, state
    );
endinterface

// File: rtl/irrigation_valve_controller.sv
// irrigation_valve_controller: drives aspersion/drip valves from the upstream request; WATER_LEVEL_CHECK_EN adds a low-water fault state
module irrigation_valve_controller #(
    parameter int unsigned ASP_SECONDS = 22
) (
    input logic                          clk,
    input logic                          rst_n,
    irrigation_valve_controller_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE     = 3'b000,
        ASP      = 3'b001,
        DRIP     = 3'b010,
        MIX_ASP  = 3'b011,
        MIX_DRIP = 3'b100,
        FAULT    = 3'b101
    } state_t;
    localparam logic [5:0] ASP_LOAD = 6'(ASP_SECONDS);
    state_t     cur, nxt;
    logic [5:0] cnt, nxt_cnt;
    logic [1:0] req;
    assign req = bus.type_of_irrigation_state;
    // next state and counter; the counter is only nonzero while in MIX_ASP so it doubles as secs_left
    always_comb begin
        nxt     = cur;
        nxt_cnt = 6'd0;
        case (cur)
            IDLE: begin
                nxt     = req == 2'b01 ? ASP : req == 2'b10 ? DRIP : req == 2'b11 ? MIX_ASP : IDLE;
                nxt_cnt = req == 2'b11 ? ASP_LOAD : 6'd0;
            end
            ASP:      nxt = req == 2'b01 ? ASP : IDLE;
            DRIP:     nxt = req == 2'b10 ? DRIP : IDLE;
            MIX_ASP: begin
                if (req != 2'b11)
                    nxt = IDLE;
                else if (!bus.tick_1s)
                    nxt_cnt = cnt;
                else if (cnt == 6'd1)
                    nxt = MIX_DRIP;
                else
                    nxt_cnt = cnt - 6'd1;
            end
            MIX_DRIP: nxt = req == 2'b11 ? MIX_DRIP : IDLE;
`ifdef WATER_LEVEL_CHECK_EN
            FAULT:    nxt = (!bus.water_low && req == 2'b00) ? IDLE : FAULT;
`endif
            default:  nxt = IDLE;
        endcase
`ifdef WATER_LEVEL_CHECK_EN
        if (bus.water_low && cur != FAULT) begin
            nxt     = FAULT;
            nxt_cnt = 6'd0;
        end
`endif
    end
`ifndef WATER_LEVEL_CHECK_EN
    logic unused_water_low;
    assign unused_water_low = bus.water_low;
`endif
    // state, counter and outputs registered from the next state so valves move one clk after the cause
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur            <= IDLE;
            cnt            <= 6'd0;
            bus.valve_asp  <= 1'b0;
            bus.valve_drip <= 1'b0;
            bus.alarm      <= 1'b0;
        end else begin
            cur            <= nxt;
            cnt            <= nxt_cnt;
            bus.valve_asp  <= nxt == ASP || nxt == MIX_ASP;
            bus.valve_drip <= nxt == DRIP || nxt == MIX_DRIP;
`ifdef WATER_LEVEL_CHECK_EN
            bus.alarm      <= nxt == FAULT;
`else
            bus.alarm      <= 1'b0;
`endif
        end
    end
    assign bus.secs_left = cnt;
    assign bus.state     = cur;
endmodule

// File: tb/tb_irrigation_valve_controller.sv
// tb_irrigation_valve_controller: directed literal checks plus randomized traffic against a request-level model
module tb_irrigation_valve_controller;
    localparam int ASP = 22;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    bit   cmp_en = 1'b0;
    irrigation_valve_controller_if bus();
    irrigation_valve_controller #(.ASP_SECONDS(ASP)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    always #5 clk = ~clk;
    // model: which request is being served (0 none), aspersion seconds remaining, fault latch
    int m_serv = 0;
    int m_rem  = 0;
    bit m_fault = 1'b0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_serv  <= 0;
            m_rem   <= 0;
            m_fault <= 1'b0;
        end
`ifdef WATER_LEVEL_CHECK_EN
        else if (m_fault) begin
            if (!bus.water_low && bus.type_of_irrigation_state == 2'd0) m_fault <= 1'b0;
        end else if (bus.water_low) begin
            m_fault <= 1'b1;
            m_serv  <= 0;
            m_rem   <= 0;
        end
`endif
        else if (m_serv != 0 && int'(bus.type_of_irrigation_state) != m_serv) begin
            m_serv <= 0;
            m_rem  <= 0;
        end else if (m_serv == 0) begin
            m_serv <= int'(bus.type_of_irrigation_state);
            m_rem  <= bus.type_of_irrigation_state == 2'd3 ? ASP : 0;
        end else if (m_serv == 3 && m_rem > 0 && bus.tick_1s)
            m_rem <= m_rem - 1;
    end
    function automatic int exp_code();
        if (m_fault) return 5;
        if (m_serv == 3) return m_rem > 0 ? 3 : 4;
        return m_serv;
    endfunction
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask
    // compare every cycle against the model, away from the rising edge
    always @(negedge clk) begin
        if (cmp_en && rst_n) begin
            chk("m_asp",   int'(bus.valve_asp),  int'((m_serv == 1) || (m_serv == 3 && m_rem > 0)));
            chk("m_drip",  int'(bus.valve_drip), int'((m_serv == 2) || (m_serv == 3 && m_rem == 0)));
            chk("m_secs",  int'(bus.secs_left),  m_serv == 3 ? m_rem : 0);
            chk("m_alarm", int'(bus.alarm),      int'(m_fault));
            chk("m_state", int'(bus.state),      exp_code());
            chk("m_excl",  int'(bus.valve_asp && bus.valve_drip), 0);
        end
    end
    task automatic step(input int r, input bit t, input bit w);
        bus.type_of_irrigation_state = 2'(r);
        bus.tick_1s = t;
        bus.water_low = w;
        @(posedge clk);
        #1;
        bus.tick_1s = 1'b0;
    endtask
    initial begin
        bus.type_of_irrigation_state = 2'd0;
        bus.tick_1s = 1'b0;
        bus.water_low = 1'b0;
        #3;
        chk("rst_state", int'(bus.state), 0);
        chk("rst_asp",   int'(bus.valve_asp), 0);
        chk("rst_secs",  int'(bus.secs_left), 0);
        chk("rst_alarm", int'(bus.alarm), 0);
        @(negedge clk);
        rst_n = 1'b1;
        cmp_en = 1'b1;
        step(0, 0, 0);
        chk("idle_hold", int'(bus.state), 0);
        step(1, 0, 0);
        chk("asp_on",   int'(bus.valve_asp), 1);
        chk("asp_drip", int'(bus.valve_drip), 0);
        step(0, 0, 0);
        chk("asp_off",  int'(bus.valve_asp), 0);
        step(3, 0, 0);
        for (int i = 0; i < ASP; i++) begin
            chk("mix_secs", int'(bus.secs_left), ASP - i);
            chk("mix_asp",  int'(bus.valve_asp), 1);
            step(3, 1, 0);
        end
        chk("mix_drip_on", int'(bus.valve_drip), 1);
        chk("mix_asp_off", int'(bus.valve_asp), 0);
        chk("mix_secs0",   int'(bus.secs_left), 0);
        step(3, 1, 0);
        chk("mix_stay", int'(bus.state), 4);
        step(1, 0, 0);
        chk("mix_break", int'(bus.state), 0);
        step(1, 0, 0);
        step(2, 0, 0);
        chk("bbm_state", int'(bus.state), 0);
        chk("bbm_valves", int'(bus.valve_asp | bus.valve_drip), 0);
        step(2, 0, 0);
        chk("bbm_drip", int'(bus.valve_drip), 1);
        step(0, 0, 0);
        step(3, 0, 0);
        for (int i = 0; i < 12; i++) step(3, 1, 0);
        chk("pre_rst_secs", int'(bus.secs_left), 10);
        #2 rst_n = 1'b0;
        #1;
        chk("async_asp",  int'(bus.valve_asp), 0);
        chk("async_secs", int'(bus.secs_left), 0);
        chk("async_state", int'(bus.state), 0);
        rst_n = 1'b1;
        step(3, 0, 0);
        chk("reload", int'(bus.secs_left), ASP);
        for (int i = 0; i < ASP - 1; i++) step(3, 1, 0);
        chk("pre_race_secs", int'(bus.secs_left), 1);
        step(1, 1, 0);
        chk("race_state", int'(bus.state), 0);
        chk("race_drip",  int'(bus.valve_drip), 0);
        step(2, 0, 0);
        step(2, 0, 0);
        chk("drip_before_low", int'(bus.state), 2);
        step(2, 0, 1);
`ifdef WATER_LEVEL_CHECK_EN
        chk("fault_alarm", int'(bus.alarm), 1);
        chk("fault_drip",  int'(bus.valve_drip), 0);
        step(3, 0, 0);
        chk("fault_hold", int'(bus.state), 5);
        step(0, 0, 0);
        chk("fault_exit", int'(bus.state), 0);
        chk("fault_clear", int'(bus.alarm), 0);
`else
        chk("low_ignored", int'(bus.state), 2);
        chk("no_alarm", int'(bus.alarm), 0);
`endif
        begin
            int r = 0;
            bit w = 1'b0;
            for (int i = 0; i < 4000; i++) begin
                if ($urandom_range(0, 39) == 0) r = int'($urandom_range(0, 3));
                if ($urandom_range(0, 59) == 0) w = ~w;
                step(r, $urandom_range(0, 2) == 0, w);
            end
        end
        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
